// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: receiver state
// encoding, 16x oversampling sample points and bit-decision helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_A   = 4'd7;
    localparam logic [3:0] SAMPLE_B   = 4'd8;
    localparam logic [3:0] SAMPLE_C   = 4'd9;
    localparam logic [3:0] BIT_END    = 4'd15;
    localparam int         DATA_BITS  = 8;

    // Two-of-three vote over the mid-bit sample window.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // High when data plus parity bit carry an odd number of ones.
    function automatic logic even_parity_bad(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle of the UART receiver: FWFT read port, fill level
// and sticky error flags. parity_err exists only with UART_RX_PARITY_EN.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 8
);
    logic [7:0]               rd_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     frame_err;
    logic                     overrun;
    logic                     err_clr;
`ifdef UART_RX_PARITY_EN
    logic                     parity_err;
`endif

    // Receiver side: produces data and status.
    modport master (
        output rd_data, rd_valid, fifo_level, frame_err, overrun,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        input  rd_ready, err_clr
    );

    // Consumer side: accepts data and clears errors.
    modport slave (
        input  rd_data, rd_valid, fifo_level, frame_err, overrun,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        output rd_ready, err_clr
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is presented
// combinationally from storage; it reads as zero while the FIFO is empty.
// A push is accepted while full only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (level_r == {(AW+1){1'b0}});
    assign full      = (level_r == FULL_LVL);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign level     = level_r;
    assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver for the dbgu link: 2-flop synchroniser, 16x oversampling
// with a 3-sample majority vote at sub-ticks 7/8/9, 8N1 framing (8E1 when
// UART_RX_PARITY_EN is defined) and an FWFT byte FIFO with sticky flags.
// The stop bit is judged at sub-tick 9 so a back-to-back start edge is seen.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 2,
    parameter int DEPTH    = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              rx,
    uart_rx_fifo_if.master    bus
);
    localparam int            TW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_e              state_r;
    rx_state_e              state_nx;
    logic                   rx_meta_r;
    logic                   rx_s_r;
    logic [TW-1:0]          tick_cnt_r;
    logic [3:0]             sub_cnt_r;
    logic                   samp_a_r;
    logic                   samp_b_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   frame_err_r;
    logic                   overrun_r;

    logic                   tick_s;
    logic                   at_c_s;
    logic                   at_end_s;
    logic                   maj_s;
    logic                   start_det_s;
    logic                   shift_s;
    logic                   bit_clr_s;
    logic                   bit_inc_s;
    logic                   push_s;
    logic                   frame_set_s;
    logic                   overrun_set_s;
    logic                   full_s;
    logic                   empty_s;
    logic [7:0]             head_s;
    logic [$clog2(DEPTH):0] level_s;
`ifdef UART_RX_PARITY_EN
    logic                   par_cap_s;
    logic                   par_set_s;
    logic                   par_bad_r;
    logic                   parity_err_r;
`endif

    assign tick_s   = (tick_cnt_r == TICK_LAST);
    assign at_c_s   = tick_s & (sub_cnt_r == SAMPLE_C);
    assign at_end_s = tick_s & (sub_cnt_r == BIT_END);
    assign maj_s    = majority3(samp_a_r, samp_b_r, rx_s_r);

    // Bring the asynchronous pin into clk through two flops, idling high.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
        end
    end

    // Oversample tick and sub-tick counters, realigned to each start edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tick_cnt_r <= {TW{1'b0}};
            sub_cnt_r  <= 4'd0;
        end else if (start_det_s) begin
            tick_cnt_r <= {TW{1'b0}};
            sub_cnt_r  <= 4'd0;
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
            sub_cnt_r  <= sub_cnt_r + 4'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Capture the first two samples of the vote window; the third is live rx_s.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            samp_a_r <= 1'b1;
            samp_b_r <= 1'b1;
        end else if (tick_s && (sub_cnt_r == SAMPLE_A)) begin
            samp_a_r <= rx_s_r;
        end else if (tick_s && (sub_cnt_r == SAMPLE_B)) begin
            samp_b_r <= rx_s_r;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nx    = state_r;
        start_det_s = 1'b0;
        shift_s     = 1'b0;
        bit_clr_s   = 1'b0;
        bit_inc_s   = 1'b0;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (!rx_s_r) begin
                    start_det_s = 1'b1;
                    state_nx    = START;
                end else begin
                    state_nx    = IDLE;
                end
            end
            START: begin
                if (at_c_s && maj_s) begin
                    state_nx  = IDLE;
                end else if (at_end_s) begin
                    bit_clr_s = 1'b1;
                    state_nx  = DATA;
                end else begin
                    state_nx  = START;
                end
            end
            DATA: begin
                if (at_c_s) begin
                    shift_s = 1'b1;
                end else if (at_end_s) begin
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        bit_inc_s = 1'b1;
                    end
                end else begin
                    state_nx = DATA;
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (at_c_s) begin
                    par_cap_s = 1'b1;
                end else if (at_end_s) begin
                    state_nx  = STOP;
                end else begin
                    state_nx  = PARITY;
                end
`else
                state_nx = IDLE;
`endif
            end
            STOP: begin
                if (at_c_s) begin
                    if (maj_s) begin
`ifdef UART_RX_PARITY_EN
                        push_s = ~par_bad_r;
`else
                        push_s = 1'b1;
`endif
                        state_nx = IDLE;
                    end else begin
                        frame_set_s = 1'b1;
                        state_nx    = BREAK;
                    end
                end else begin
                    state_nx = STOP;
                end
            end
            BREAK: begin
                if (rx_s_r) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = BREAK;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Data shift register (LSB first) and bit counter.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
        end else begin
            if (shift_s) begin
                shift_r <= {maj_s, shift_r[7:1]};
            end
            if (bit_clr_s) begin
                bit_cnt_r <= 3'd0;
            end else if (bit_inc_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_set_s = par_cap_s & even_parity_bad(shift_r, maj_s);

    // Remember a parity mismatch for the current frame and keep the sticky flag.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (bit_clr_s) begin
                par_bad_r <= 1'b0;
            end else if (par_cap_s) begin
                par_bad_r <= par_set_s;
            end
            if (par_set_s) begin
                parity_err_r <= 1'b1;
            end else if (bus.err_clr) begin
                parity_err_r <= 1'b0;
            end
        end
    end

    assign bus.parity_err = parity_err_r;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (bus.rd_ready),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level_s)
    );

    // A full FIFO always has a valid head, so rd_ready alone means a pop frees space.
    assign overrun_set_s = push_s & full_s & ~bus.rd_ready;

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (frame_set_s) begin
                frame_err_r <= 1'b1;
            end else if (bus.err_clr) begin
                frame_err_r <= 1'b0;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (bus.err_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign bus.rd_data    = head_s;
    assign bus.rd_valid   = ~empty_s;
    assign bus.fifo_level = level_s;
    assign bus.frame_err  = frame_err_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at BAUD_DIV=2 (32 clocks per bit).
// Frames are driven on falling clock edges; outputs are sampled there too.
// A start edge driven at falling edge N0 is decided (stop bit) at the rising
// edge just before falling edge N0 + 32*(head bits) + 23.
module tb_uart_rx_fifo;
    localparam int BIT   = 32;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic n_reset;
    logic rx;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .BAUD_DIV (2),
        .DEPTH    (DEPTH)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .rx      (rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit plus eight data bits, LSB first.
    task automatic send_bits(input logic [7:0] b);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT);
        end
    endtask

    // Everything before the stop bit, with correct parity when enabled.
    task automatic send_head(input logic [7:0] b);
        send_bits(b);
`ifdef UART_RX_PARITY_EN
        rx = ^b;
        wait_clk(BIT);
`endif
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_head(b);
        rx = 1'b1;
        wait_clk(BIT);
    endtask

    task automatic pulse_pop();
        bus.rd_ready = 1'b1;
        wait_clk(1);
        bus.rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        wait_clk(1);
        bus.err_clr = 1'b0;
    endtask

    initial begin
        n_reset      = 1'b0;
        rx           = 1'b1;
        bus.rd_ready = 1'b0;
        bus.err_clr  = 1'b0;
        wait_clk(3);
        n_reset = 1'b1;
        wait_clk(2);

        // Reset state
        check("rst_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_data", 32'(bus.rd_data), 32'h00);
        check("rst_level", 32'(bus.fifo_level), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);
        wait_clk(40);

        // Single byte 0xA5 with latency window around the stop decision
        send_head(8'hA5);
        rx = 1'b1;
        wait_clk(8);
        check("a5_early_valid", 32'(bus.rd_valid), 32'd0);
        wait_clk(24);
        check("a5_valid", 32'(bus.rd_valid), 32'd1);
        check("a5_data", 32'(bus.rd_data), 32'hA5);
        check("a5_level", 32'(bus.fifo_level), 32'd1);
        pulse_pop();
        check("a5_pop_level", 32'(bus.fifo_level), 32'd0);
        check("a5_pop_data", 32'(bus.rd_data), 32'h00);
        check("a5_pop_valid", 32'(bus.rd_valid), 32'd0);

        // 6-clock low glitch is rejected
        rx = 1'b0;
        wait_clk(6);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("glitch_level", 32'(bus.fifo_level), 32'd0);
        check("glitch_ferr", 32'(bus.frame_err), 32'd0);
        check("glitch_ovr", 32'(bus.overrun), 32'd0);

        // 0x3C with low stop bit, then line held low (break)
        send_head(8'h3C);
        rx = 1'b0;
        wait_clk(BIT + 5 * BIT);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("brk_ferr", 32'(bus.frame_err), 32'd1);
        check("brk_level", 32'(bus.fifo_level), 32'd0);
        pulse_clr();
        check("brk_clr", 32'(bus.frame_err), 32'd0);
        wait_clk(2 * BIT);
        check("brk_once", 32'(bus.frame_err), 32'd0);

        // DEPTH+1 back-to-back bytes with no reads: ninth is dropped
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i));
        end
        wait_clk(8);
        check("ovf_level", 32'(bus.fifo_level), 32'd8);
        check("ovf_ovr", 32'(bus.overrun), 32'd1);
        check("ovf_ferr", 32'(bus.frame_err), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            check("ovf_order", 32'(bus.rd_data), 32'(i));
            pulse_pop();
        end
        check("ovf_drained", 32'(bus.fifo_level), 32'd0);
        pulse_clr();
        check("ovf_clr", 32'(bus.overrun), 32'd0);

        // Full FIFO with pop on the exact push cycle of the ninth byte
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h10 + 8'(i));
        end
        check("full_level", 32'(bus.fifo_level), 32'd8);
        send_head(8'h18);
        rx = 1'b1;
        wait_clk(22);
        bus.rd_ready = 1'b1;
        wait_clk(1);
        bus.rd_ready = 1'b0;
        wait_clk(9);
        check("pp_level", 32'(bus.fifo_level), 32'd8);
        check("pp_ovr", 32'(bus.overrun), 32'd0);
        check("pp_head", 32'(bus.rd_data), 32'h11);

        // err_clr on the same cycle as a new overrun: set wins
        send_head(8'h19);
        rx = 1'b1;
        wait_clk(22);
        bus.err_clr = 1'b1;
        wait_clk(1);
        bus.err_clr = 1'b0;
        wait_clk(9);
        check("setwin_ovr", 32'(bus.overrun), 32'd1);
        check("setwin_level", 32'(bus.fifo_level), 32'd8);
        check("setwin_head", 32'(bus.rd_data), 32'h11);

        // Reset in the middle of DATA of 0xFF with three bytes queued
        for (int i = 0; i < 5; i++) begin
            pulse_pop();
        end
        check("pre_rst_level", 32'(bus.fifo_level), 32'd3);
        rx = 1'b0;
        wait_clk(BIT);
        rx = 1'b1;
        wait_clk(4 * BIT + 10);
        n_reset = 1'b0;
        #1;
        check("mid_rst_level", 32'(bus.fifo_level), 32'd0);
        check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("mid_rst_data", 32'(bus.rd_data), 32'h00);
        check("mid_rst_ovr", 32'(bus.overrun), 32'd0);
        wait_clk(2);
        n_reset = 1'b1;
        wait_clk(6 * BIT);
        send_frame(8'h5A);
        check("post_rst_valid", 32'(bus.rd_valid), 32'd1);
        check("post_rst_data", 32'(bus.rd_data), 32'h5A);
        check("post_rst_level", 32'(bus.fifo_level), 32'd1);
        check("post_rst_ferr", 32'(bus.frame_err), 32'd0);
        pulse_pop();

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity bit must be 1
        send_bits(8'h07);
        rx = 1'b0;
        wait_clk(BIT);
        rx = 1'b1;
        wait_clk(BIT + 8);
        check("par_bad_err", 32'(bus.parity_err), 32'd1);
        check("par_bad_level", 32'(bus.fifo_level), 32'd0);
        pulse_clr();
        check("par_clr", 32'(bus.parity_err), 32'd0);
        send_bits(8'h07);
        rx = 1'b1;
        wait_clk(BIT);
        wait_clk(BIT + 8);
        check("par_ok_level", 32'(bus.fifo_level), 32'd1);
        check("par_ok_data", 32'(bus.rd_data), 32'h07);
        check("par_ok_err", 32'(bus.parity_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
